regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file with a per-register scoreboard, for the
//  pipelined CPU decode/writeback stages. Provides NRD combinational read ports with
//  optional writeback bypass, and NWR synchronous write ports. Busy bits are set at issue
//  and cleared at writeback. After reset, an init sequencer zeroes every entry.
// PARAMETERS
//  XLEN     32  data width
//  NREGS    32  number of registers (power of two, >=2); AW = $clog2(NREGS)
//  NRD      2   read ports
//  NWR      2   write ports
//  BYPASS   1   1 = same-cycle write data/clear forwarded to reads
//  ZERO_REG 1   1 = register 0 hard-wired to zero, never busy
// PORTS
//  clk       in  1         clock, rising edge
//  rst_n     in  1         reset, asynchronous, active-low
//  rd_addr   in  NRD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data   out NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rd_busy   out NRD       pending-write flag for each read address
//  wr_en     in  NWR       write enables
//  wr_addr   in  NWR*AW    write addresses
//  wr_data   in  NWR*XLEN  write data
//  iss_en    in  1         an instruction with a destination issues this cycle
//  iss_addr  in  AW        destination of the issuing instruction
//  init_done out 1         0 while clearing, 1 in RUN
//  dbg_addr  in  AW        debug read address (replaces fixed x31 tap)
//  dbg_data  out XLEN      raw storage at dbg_addr, no bypass, no zero forcing
// BEHAVIOUR
//  FSM states: CLEAR, RUN. On rst_n low, asynchronously: state=CLEAR, clr_cnt=0, busy=0,
//   init_done=0. Storage is not async reset.
//  CLEAR: each cycle writes 0 to RF[clr_cnt] and increments clr_cnt. At clr_cnt==NREGS-1
//   the FSM enters RUN on the next edge, so CLEAR lasts exactly NREGS cycles. wr_en and
//   iss_en are ignored. rd_data=0 and rd_busy=all-ones, which stalls the pipe.
//  RUN: stays in RUN until reset. If rst_n is asserted mid-operation, the block returns
//   to CLEAR and the full sweep repeats.
//  Write: on the rising edge, RF[wr_addr[j]] <= wr_data[j] for each j with wr_en[j].
//   If ports collide on one address, the highest j wins. Writes to r0 are dropped when
//   ZERO_REG=1.
//  Read: combinational. If ZERO_REG and addr==0, rd_data=0 and rd_busy=0.
//   Else if BYPASS and some wr_en[j] targets addr, rd_data=wr_data of the highest such j
//   and rd_busy=0.
//   Else rd_data=RF[addr] and rd_busy=busy[addr].
//  Scoreboard: at the edge, busy[r] is cleared if any wr_en targets r, and set if
//   iss_en & iss_addr==r. Set beats clear, because a new producer supersedes the old one.
//   Issue is not visible in rd_busy until the next cycle. iss to r0 is ignored when
//   ZERO_REG=1.
//  Latency: read 0 cycles; write and busy update visible without bypass 1 cycle after
//   the edge.
// STRUCTURE
//  Package rf_pkg holds the state encoding (CLEAR=1'b0, RUN=1'b1) and a clog2 function.
//  Sub-module rf_scoreboard (NREGS, NWR, AW) holds the busy vector and its
//   set/clear/priority logic and exposes busy[NREGS-1:0].
//  Top-level holds storage, bypass muxes, the CLEAR sequencer and dbg tap.
// TESTING
//  1 Reset, then hold: init_done=0 for exactly 32 cycles, then 1. All reads return 0
//    with busy=0 (rd_busy=2'b11 during CLEAR).
//  2 iss r5, next cycle read r5 -> busy=1. Write r5=0xDEADBEEF on port 0 that cycle ->
//    rd_data=0xDEADBEEF, busy=0 same cycle. Next cycle busy=0 and value is held.
//  3 Same-cycle wr port0 r7=0x1, port1 r7=0x2 -> read r7 returns 0x2 combinationally
//    and after the edge.
//  4 Same-cycle iss r9 and write r9=0x55 -> RF[9]=0x55 and busy[9]=1 next cycle.
//  5 Write r0=0xFFFF_FFFF and iss r0 -> rd_data 0, busy 0; dbg_data at r0 is 0.
//  6 Pulse rst_n low mid-RUN with r3=0x1234 and busy[3]=1 -> busy clears immediately.
//    After 32 cycles r3 reads 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: sequencer state encoding
// and an elaboration-time clog2 helper.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: cleared by writeback, set by issue; a same-edge issue
// overrides a clear because the new producer supersedes the old one.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j]) busy_next[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en) busy_next[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with writeback bypass, busy scoreboard and a
// post-reset clear sequencer that zeroes every entry before accepting traffic.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                init_done,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    rf_state_e        state, state_next;
    logic [AW-1:0]    clr_cnt, clr_cnt_next;
    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy;
    logic [NWR-1:0]   wr_ok;
    logic             iss_ok;
    logic [AW-1:0]    ra;

    // Writes and issues are only honoured once the clear sweep has finished.
    assign wr_ok  = (state == RUN) ? wr_en : '0;
    assign iss_ok = (state == RUN) && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        init_done    = 1'b0;
        case (state)
            CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == AW'(NREGS - 1)) state_next = RUN;
            end
            RUN: init_done = 1'b1;
            default: state_next = CLEAR;
        endcase
    end

    // Storage has no reset; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            rf[clr_cnt] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0)))
                    rf[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    rf_scoreboard #(
        .NREGS(NREGS),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .iss_en  (iss_ok),
        .iss_addr(iss_addr),
        .busy    (busy)
    );

    // Ascending port scan so the highest-numbered matching writer wins.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (state == CLEAR) begin
                rd_busy[i] = 1'b1;
            end else if (!((ZERO_REG != 0) && (ra == '0))) begin
                rd_data[i*XLEN +: XLEN] = rf[ra];
                rd_busy[i]              = busy[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_ok[j] && (wr_addr[j*AW +: AW] == ra)) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                            rd_busy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: behavioural model compared every cycle plus
// directed scenarios with literal expectations.
module tb_regfile_mp_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic                init_done;
    logic [AW-1:0]       dbg_addr = '0;
    logic [XLEN-1:0]     dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    // Model: register contents, busy flags, cycles of clearing completed.
    logic [XLEN-1:0] model_rf [NREGS];
    logic            model_busy [NREGS];
    int              clear_cycles = 0;
    bit              ever_inited = 1'b0;

    regfile_mp_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .init_done(init_done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_cycles <= 0;
            for (int r = 0; r < NREGS; r++) model_busy[r] <= 1'b0;
        end else if (clear_cycles < NREGS) begin
            model_rf[clear_cycles] <= '0;
            clear_cycles           <= clear_cycles + 1;
            if (clear_cycles == NREGS - 1) ever_inited <= 1'b1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    if (wr_addr[j*AW +: AW] != 0) model_rf[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                    model_busy[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) model_busy[iss_addr] <= 1'b1;
        end
    end

    // Compare process, mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        logic [XLEN-1:0] ed;
        logic            eb;
        logic [AW-1:0]   a;
        bit              hit;
        check("init_done", {31'b0, init_done}, {31'b0, clear_cycles == NREGS});
        for (int i = 0; i < NRD; i++) begin
            a   = rd_addr[i*AW +: AW];
            hit = 1'b0;
            ed  = '0;
            eb  = 1'b0;
            if (clear_cycles < NREGS) begin
                eb = 1'b1;
            end else if (a != 0) begin
                for (int j = NWR - 1; j >= 0; j--) begin
                    if (!hit && wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                        ed  = wr_data[j*XLEN +: XLEN];
                        hit = 1'b1;
                    end
                end
                if (!hit) begin
                    ed = model_rf[a];
                    eb = model_busy[a];
                end
            end
            check($sformatf("rd_data[%0d]", i), rd_data[i*XLEN +: XLEN], ed);
            check($sformatf("rd_busy[%0d]", i), {31'b0, rd_busy[i]}, {31'b0, eb});
        end
        if (ever_inited) check("dbg_data", dbg_data, model_rf[dbg_addr]);
    end

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int cnt;
        idle();
        repeat (3) next_cycle();

        // Clear sequence length and outputs during/after it.
        rst_n = 1'b1;
        #1;
        check("clear_rd_busy", {30'b0, rd_busy}, 32'h3);
        check("clear_rd_data", rd_data[XLEN-1:0], 32'h0);
        cnt = 0;
        while (!init_done && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("clear_cycles", cnt, 32);
        #1;
        rd_addr = {5'd2, 5'd1};
        #1;
        check("post_clear_r1", rd_data[0 +: XLEN], 32'h0);
        check("post_clear_busy", {30'b0, rd_busy}, 32'h0);

        // Issue then bypassed writeback.
        next_cycle();
        iss_en = 1'b1; iss_addr = 5'd5;
        next_cycle();
        idle();
        rd_addr[0 +: AW] = 5'd5;
        #1;
        check("iss_busy_r5", {31'b0, rd_busy[0]}, 32'h1);
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 32'hDEADBEEF;
        #1;
        check("bypass_r5", rd_data[0 +: XLEN], 32'hDEADBEEF);
        check("bypass_busy_r5", {31'b0, rd_busy[0]}, 32'h0);
        next_cycle();
        idle();
        #1;
        check("held_r5", rd_data[0 +: XLEN], 32'hDEADBEEF);
        check("held_busy_r5", {31'b0, rd_busy[0]}, 32'h0);

        // Write-port collision, highest port wins.
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2, 32'h1};
        rd_addr[AW +: AW] = 5'd7;
        #1;
        check("collide_bypass", rd_data[XLEN +: XLEN], 32'h2);
        next_cycle();
        idle();
        #1;
        check("collide_stored", rd_data[XLEN +: XLEN], 32'h2);

        // Same-edge issue and write: set wins.
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: XLEN] = 32'h55;
        next_cycle();
        idle();
        rd_addr[0 +: AW] = 5'd9;
        #1;
        check("set_beats_clear_data", rd_data[0 +: XLEN], 32'h55);
        check("set_beats_clear_busy", {31'b0, rd_busy[0]}, 32'h1);

        // r0 is hard-wired.
        iss_en = 1'b1; iss_addr = 5'd0;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd0; wr_data[0 +: XLEN] = 32'hFFFF_FFFF;
        rd_addr[0 +: AW] = 5'd0;
        dbg_addr = 5'd0;
        #1;
        check("r0_data", rd_data[0 +: XLEN], 32'h0);
        check("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
        next_cycle();
        idle();
        #1;
        check("r0_dbg", dbg_data, 32'h0);
        check("r0_busy_after", {31'b0, rd_busy[0]}, 32'h0);

        // Mid-run reset.
        iss_en = 1'b1; iss_addr = 5'd3;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 32'h1234;
        next_cycle();
        idle();
        rd_addr[0 +: AW] = 5'd3;
        #1;
        check("r3_busy_before", {31'b0, rd_busy[0]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("r3_busy_async_clear", {31'b0, dut.busy[3]}, 32'h0);
        check("reset_init_done", {31'b0, init_done}, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        repeat (NREGS) next_cycle();
        #1;
        check("r3_after_clear", rd_data[0 +: XLEN], 32'h0);
        check("r3_busy_after_clear", {31'b0, rd_busy[0]}, 32'h0);

        // Randomized traffic, with a mid-run reset.
        for (int k = 0; k < 1500; k++) begin
            next_cycle();
            if (k == 700) rst_n = 1'b0;
            else          rst_n = 1'b1;
            for (int j = 0; j < NWR; j++) begin
                wr_en[j] = ($urandom_range(0, 2) != 0);
                wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3))
                                                                  : AW'($urandom_range(0, NREGS - 1));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int i = 0; i < NRD; i++) begin
                rd_addr[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                                  : AW'($urandom_range(0, NREGS - 1));
            end
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                   : AW'($urandom_range(0, NREGS - 1));
            dbg_addr = AW'($urandom_range(0, NREGS - 1));
        end
        next_cycle();
        idle();
        repeat (2) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
